// File: rtl/axi_wr_pkg.sv
// Shared types for the AXI write engine: response codes and FSM states.
// Optional feature macro AXWR_PARTIAL_STRB_EN is consumed by axi_wr_engine.
package axi_wr_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WRITE = 2'b01,
    CHECK = 2'b10
  } state_t;

endpackage

// File: rtl/axi_wr_bfifo.sv
// Write-response FIFO: power-of-two depth, head always visible on dout.
// Occupancy count is exported so the engine can reserve slots.
module axi_wr_bfifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push;
  logic             do_pop;

  assign full  = (cnt_q == CNT_W'(DEPTH));
  assign empty = (cnt_q == '0);
  assign count = cnt_q;
  assign dout  = mem_q[rptr_q];

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (do_push) begin
      mem_d[wptr_q] = din;
      wptr_d        = wptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rptr_d = rptr_q + PTR_W'(1);
    end
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/axi_wr_engine.sv
// AXI write slave bridging AW/W/B to a single-cycle register write port.
// Define AXWR_PARTIAL_STRB_EN to issue writes with any strobe pattern.
module axi_wr_engine
  import axi_wr_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int B_DEPTH = 2,
  localparam int STRB_W = DATA_W / 8
) (
  input  logic              iCLK,
  input  logic              iRSTN,
  input  logic [31:0]       iAWADDR,
  input  logic              iAWVALID,
  output logic              oAWREADY,
  input  logic [DATA_W-1:0] iWDATA,
  input  logic [STRB_W-1:0] iWSTRB,
  input  logic              iWVALID,
  output logic              oWREADY,
  output logic [1:0]        oBRESP,
  output logic              oBVALID,
  input  logic              iBREADY,
  input  logic              iARVALID,
  output logic [ADDR_W-1:0] oPWADR,
  output logic [DATA_W-1:0] oPWDAT,
  output logic [STRB_W-1:0] oPWSTB,
  output logic              oPWRTE,
  input  logic              iPERR
);

  localparam int CNT_W = $clog2(B_DEPTH) + 1;

  state_t              state_q, state_d;
  logic                aw_held_q, aw_held_d;
  logic                w_held_q, w_held_d;
  logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic                strb_err_q, strb_err_d;

  logic                strb_ok;
  logic [STRB_W-1:0]   issue_stb;
  logic                room;
  logic                aw_hs;
  logic                w_hs;
  logic                fifo_push;
  resp_t               push_resp;
  logic                fifo_pop;
  logic [1:0]          fifo_head;
  logic                fifo_full;
  logic                fifo_empty;
  logic [CNT_W-1:0]    fifo_cnt;
  logic                unused_addr_hi;

  assign unused_addr_hi = ^iAWADDR[31:ADDR_W] ^ fifo_full;

`ifdef AXWR_PARTIAL_STRB_EN
  assign strb_ok   = 1'b1;
  assign issue_stb = wstrb_q;
`else
  assign strb_ok   = &wstrb_q;
  assign issue_stb = '1;
`endif

  // A write in WRITE/CHECK already owns a FIFO slot it will push into.
  assign room = (int'(fifo_cnt) + ((state_q != IDLE) ? 1 : 0)) < B_DEPTH;

  assign oAWREADY = (state_q == IDLE) & ~aw_held_q & ~iARVALID & room;
  assign oWREADY  = (state_q == IDLE) & ~w_held_q & ~iARVALID & room;
  assign aw_hs    = iAWVALID & oAWREADY;
  assign w_hs     = iWVALID & oWREADY;

  always_comb begin
    state_d    = state_q;
    aw_held_d  = aw_held_q;
    w_held_d   = w_held_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    strb_err_d = strb_err_q;
    fifo_push  = 1'b0;
    push_resp  = OKAY;
    oPWRTE     = 1'b0;
    oPWADR     = '0;
    oPWDAT     = '0;
    oPWSTB     = '0;
    unique case (state_q)
      IDLE: begin
        if (aw_hs) begin
          aw_held_d = 1'b1;
          awaddr_d  = iAWADDR[ADDR_W-1:0];
        end
        if (w_hs) begin
          w_held_d = 1'b1;
          wdata_d  = iWDATA;
          wstrb_d  = iWSTRB;
        end
        if (aw_held_d && w_held_d) state_d = WRITE;
      end
      WRITE: begin
        aw_held_d  = 1'b0;
        w_held_d   = 1'b0;
        strb_err_d = ~strb_ok;
        if (strb_ok) begin
          oPWRTE = 1'b1;
          oPWADR = awaddr_q;
          oPWDAT = wdata_q;
          oPWSTB = issue_stb;
        end
        state_d = CHECK;
      end
      CHECK: begin
        fifo_push = 1'b1;
        push_resp = (strb_err_q | iPERR) ? SLVERR : OKAY;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRSTN) begin
    if (!iRSTN) begin
      state_q    <= IDLE;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      strb_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      aw_held_q  <= aw_held_d;
      w_held_q   <= w_held_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      strb_err_q <= strb_err_d;
    end
  end

  assign fifo_pop = ~fifo_empty & iBREADY;

  axi_wr_bfifo #(
    .DEPTH (B_DEPTH),
    .WIDTH (2)
  ) u_bfifo (
    .clk   (iCLK),
    .rst_n (iRSTN),
    .push  (fifo_push),
    .din   (push_resp),
    .pop   (fifo_pop),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  assign oBVALID = ~fifo_empty;
  assign oBRESP  = fifo_empty ? 2'b00 : fifo_head;

endmodule
